// File: rtl/sdr_rd_packer.sv
// Packs SDRAM read-back words into per-line UDP payload packets: a header word, then H_PIXELS pixels.
// A small holding FIFO absorbs controller read bursts while the header is being inserted.
module sdr_rd_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned H_PIXELS   = 640,
  parameter int unsigned V_LINES    = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  HDR_MAGIC  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Sdr_rd_en,
  input  logic [DATA_WIDTH-1:0]         Sdr_rd_dout,
  output logic                          udp_wr_en,
  output logic [DATA_WIDTH-1:0]         udp_wr_data,
  output logic                          udp_sop,
  output logic                          udp_eop,
  output logic                          frame_done,
  output logic                          ovf_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PIX_W = 24;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned PC_W  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int unsigned LN_W  = 16;
  localparam int unsigned FR_W  = 8;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [PC_W-1:0]   pix_q, pix_d;
  logic [LN_W-1:0]   line_q, line_d;
  logic [FR_W-1:0]   frame_q, frame_d;

  logic                  pop_c, push_c, drop_c;
  logic                  wr_en_d, sop_d, eop_d, done_d;
  logic [DATA_WIDTH-1:0] data_d;

  // Upper input byte carries no pixel information.
  logic unused_hi;
  assign unused_hi = ^Sdr_rd_dout[DATA_WIDTH-1:PIX_W];

  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  assign push_c = Sdr_rd_en && ((level_q != LW'(FIFO_DEPTH)) || pop_c);
  assign drop_c = Sdr_rd_en && !push_c;

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= Sdr_rd_dout[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      line_q      <= '0;
      frame_q     <= '0;
      udp_wr_en   <= 1'b0;
      udp_wr_data <= '0;
      udp_sop     <= 1'b0;
      udp_eop     <= 1'b0;
      frame_done  <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      udp_wr_en   <= wr_en_d;
      udp_wr_data <= data_d;
      udp_sop     <= sop_d;
      udp_eop     <= eop_d;
      frame_done  <= done_d;
      ovf_err     <= ovf_err | drop_c;
    end
  end

  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    wr_en_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    done_d  = 1'b0;
    data_d  = '0;
    pix_d   = pix_q;
    line_d  = line_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (level_q != '0) state_d = HDR;
      end
      HDR: begin
        wr_en_d = 1'b1;
        sop_d   = 1'b1;
        data_d  = DATA_WIDTH'({HDR_MAGIC, frame_q, line_q});
        state_d = DATA;
      end
      DATA: begin
        if (level_q != '0) begin
          pop_c   = 1'b1;
          wr_en_d = 1'b1;
          data_d  = DATA_WIDTH'(mem[rd_ptr_q]);
          if (pix_q == PC_W'(H_PIXELS - 1)) begin
            eop_d = 1'b1;
            pix_d = '0;
            // Post-pop occupancy: anything left, or a word arriving now.
            state_d = ((level_q > LW'(1)) || Sdr_rd_en) ? HDR : IDLE;
            if (line_q == LN_W'(V_LINES - 1)) begin
              done_d  = 1'b1;
              line_d  = '0;
              frame_d = frame_q + FR_W'(1);
            end else begin
              line_d = line_q + LN_W'(1);
            end
          end else begin
            pix_d = pix_q + PC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_level = level_q;

endmodule
